display_write_buffer: RTL and testbench
=======================================

# display_write_buffer

Posted-write buffer and ordering bridge between the CPU data bus and the memory-mapped display controller (region 0xFF000000 and up). CPU stores to the display region go into a small FIFO and complete in one cycle, so the CPU does not stall while the display controller is busy. Loads from the region drain the FIFO first, then issue a single read, which keeps the CPU's view of display registers and framebuffer in program order. The block sits between the system address decoder and `display_controller`; it replaces the direct `display_select`-gated enables.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; a power of two, minimum 2.
- `DISPLAY_BASE`, 32'hFF000000: an address is in the display region when it is greater than or equal to this value.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `cpu_addr`  in  32  CPU byte address.
- `cpu_write_data`  in  32  store data.
- `cpu_byte_enable`  in  4  store byte lanes.
- `cpu_write_enable`  in  1  store request.
- `cpu_read_enable`  in  1  load request.
- `cpu_read_data`  out  32  load result; valid when `cpu_ready` is high in the cycle that completes a load.
- `cpu_ready`  out  1  the current request completes this cycle; the CPU holds its request while this is low.
- `disp_addr`  out  32  address to the display controller.
- `disp_write_data`  out  32  data to the display controller.
- `disp_byte_enable`  out  4  byte lanes to the display controller.
- `disp_write_enable`  out  1  the FIFO head is presented for writing.
- `disp_read_enable`  out  1  read strobe to the display controller.
- `disp_read_data`  in  32  display read data; returned one cycle after the read is accepted.
- `disp_ready`  in  1  the display controller accepts this cycle's write or read.
- `stall_count`  out  16  CPU stall cycles; see Configuration.

## Operation
- A request is in-region when `cpu_addr` ≥ `DISPLAY_BASE`. Out-of-region requests are ignored and `cpu_ready` is high.
- If `cpu_write_enable` and `cpu_read_enable` are both high, the request is a store. The read enable is ignored.
- Store: pushed as {addr, data, byte_enable} when the FIFO is not full. `cpu_ready` = !full, combinational. A push is never accepted while the FIFO is full, even if a pop happens in the same cycle (no bypass).
- Display side: `disp_write_enable` = !empty and FSM in IDLE or DRAIN. The `disp_*` outputs carry the head entry. The head pops when `disp_write_enable && disp_ready`.
- FSM states:
  - IDLE: an in-region load → DRAIN.
  - DRAIN: when the FIFO is empty → RD_ISSUE. New stores are not accepted; `cpu_ready` is low.
  - RD_ISSUE: `disp_read_enable` = 1 and `disp_addr` = `cpu_addr`. On `disp_ready` → RD_WAIT.
  - RD_WAIT: capture `disp_read_data` into the `cpu_read_data` register, then → DONE.
  - DONE: `cpu_ready` = 1 for exactly one cycle, then → IDLE.
- Loads entering with an empty FIFO still pass through DRAIN (one cycle).
- `cpu_read_data` holds its last value until the next capture.
- Count: (DEPTH+1)-state occupancy counter `$clog2(DEPTH)+1` bits wide. Read and write pointers are `$clog2(DEPTH)` bits wide and wrap modulo DEPTH.

## Timing
- Reset values: FIFO empty, pointers 0, FSM IDLE, `cpu_read_data` 0, `disp_write_enable` 0, `disp_read_enable` 0, `disp_addr`/`disp_write_data` 0, `disp_byte_enable` 0, `stall_count` 0. `cpu_ready` is 1 when no request is present.
- Store: accepted in cycle N; the entry is at the head (if the FIFO was empty) in cycle N+1.
- Load with an empty FIFO and `disp_ready` held high: request in cycle N, DRAIN N+1, RD_ISSUE N+2, RD_WAIT N+3, DONE N+4 with `cpu_ready` = 1. Latency is 4 cycles plus drain time plus any `disp_ready` stalls.
- Push and pop in the same cycle (not full): the count is unchanged.
- Reset asserted mid-operation: immediate return to the reset state. Buffered writes are discarded, and an in-flight read is dropped with no `cpu_ready` pulse.

## Configuration
- `DISPLAY_WB_STATS_EN` defined: `stall_count` increments, saturating at 16'hFFFF, on every cycle with an in-region request and `cpu_ready` low.
- `DISPLAY_WB_STATS_EN` undefined: `stall_count` is tied to 0 and no counter logic is generated. The port stays present in both builds.

## Structure
- Package `display_bus_pkg`:
  - `DISPLAY_BASE` default;
  - `wb_entry_t` struct {addr[31:0], data[31:0], be[3:0]};
  - `wb_state_t` enum {IDLE, DRAIN, RD_ISSUE, RD_WAIT, DONE}.
- One sub-module, `wb_sync_fifo`: parameterised depth, push/pop, full/empty, `wb_entry_t` payload. The FSM, the decode and the statistics counter live in the top.

## Test plan
- 8 stores to 0xFF000000..0xFF00001C with `disp_ready` = 0: 8 accepted, `cpu_ready` low on the 9th; `stall_count` increments with the macro defined.
- Raise `disp_ready`: 8 writes leave in order, one per cycle, with matching addr, data and byte-enable; then `disp_write_enable` = 0.
- 3 buffered stores, then a load from 0xFF000010 with a read returning 32'hCAFEF00D: all 3 writes appear before `disp_read_enable`, and `cpu_read_data` = 32'hCAFEF00D with a one-cycle `cpu_ready` pulse.
- Load from an empty FIFO with `disp_ready` = 1: `cpu_ready` pulse exactly 4 cycles after the request.
- Store to 0x00001000 and write and read enables both high in-region: no push for the out-of-region store, and the dual-enable request is treated as a store.
- Assert `reset` during RD_WAIT: outputs at reset values in the same cycle, FIFO empty, no `cpu_ready` pulse.

Source files
------------

// File: rtl/display_bus_pkg.sv
// Shared types for the display write buffer.
// Entry payload, FSM states and the default display region base.
package display_bus_pkg;

  localparam logic [31:0] DISPLAY_BASE_DEFAULT = 32'hFF00_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wb_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    RD_ISSUE,
    RD_WAIT,
    DONE
  } wb_state_t;

endpackage

// File: rtl/wb_sync_fifo.sv
// Synchronous FIFO of posted display writes.
// Head is presented combinationally; push is refused when full.
module wb_sync_fifo
  import display_bus_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // storage is never read unless the slot holds a valid entry
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // pointers wrap modulo DEPTH; count tracks occupancy 0..DEPTH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/display_write_buffer.sv
// Posted-write buffer and load-ordering bridge to the display controller.
// Optional stall statistics under `DISPLAY_WB_STATS_EN.
module display_write_buffer
  import display_bus_pkg::*;
#(
  parameter int          DEPTH        = 8,
  parameter logic [31:0] DISPLAY_BASE = DISPLAY_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_write_data,
  input  logic [3:0]  cpu_byte_enable,
  input  logic        cpu_write_enable,
  input  logic        cpu_read_enable,
  output logic [31:0] cpu_read_data,
  output logic        cpu_ready,
  output logic [31:0] disp_addr,
  output logic [31:0] disp_write_data,
  output logic [3:0]  disp_byte_enable,
  output logic        disp_write_enable,
  output logic        disp_read_enable,
  input  logic [31:0] disp_read_data,
  input  logic        disp_ready,
  output logic [15:0] stall_count
);

  wb_state_t state;
  wb_state_t state_nxt;
  wb_entry_t head;
  wb_entry_t wr_entry;
  logic      in_region;
  logic      st_req;
  logic      ld_req;
  logic      full;
  logic      empty;
  logic      push;
  logic      pop;

  assign in_region = (cpu_addr >= DISPLAY_BASE);
  assign st_req    = in_region && cpu_write_enable;
  assign ld_req    = in_region && cpu_read_enable
                  && !cpu_write_enable;

  assign wr_entry = '{addr: cpu_addr,
                      data: cpu_write_data,
                      be:   cpu_byte_enable};

  assign push = (state == IDLE) && st_req && !full;
  assign pop  = disp_write_enable && disp_ready;

  assign disp_write_enable = !empty
    && ((state == IDLE) || (state == DRAIN));
  assign disp_read_enable = (state == RD_ISSUE);

  wb_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (wr_entry),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // display bus mux: FIFO head while writing, CPU address while reading
  always_comb begin
    disp_addr        = '0;
    disp_write_data  = '0;
    disp_byte_enable = '0;
    if (disp_write_enable) begin
      disp_addr        = head.addr;
      disp_write_data  = head.data;
      disp_byte_enable = head.be;
    end else if (disp_read_enable) begin
      disp_addr = cpu_addr;
    end
  end

  // CPU handshake: stores wait only for space, loads wait for DONE
  always_comb begin
    cpu_ready = 1'b1;
    unique case (state)
      IDLE:    cpu_ready = st_req ? !full : !ld_req;
      DONE:    cpu_ready = 1'b1;
      default: cpu_ready = !(st_req || ld_req);
    endcase
  end

  // load sequencing: drain posted writes, then one read
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (ld_req) state_nxt = DRAIN;
      DRAIN:    if (empty) state_nxt = RD_ISSUE;
      RD_ISSUE: if (disp_ready) state_nxt = RD_WAIT;
      RD_WAIT:  state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // read data arrives the cycle after the read is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 cpu_read_data <= '0;
    else if (state == RD_WAIT) cpu_read_data <= disp_read_data;
  end

`ifdef DISPLAY_WB_STATS_EN
  logic [15:0] stall_q;

  // saturating count of cycles an in-region request is held off
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if ((st_req || ld_req) && !cpu_ready
                 && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_display_write_buffer.sv
// Self-checking bench for display_write_buffer.
// Queue-based model plus directed literal expectations.
module tb_display_write_buffer;

  localparam int DEPTH = 8;
  localparam logic [31:0] BASE = 32'hFF00_0000;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_write_data = '0;
  logic [3:0]  cpu_byte_enable = '0;
  logic        cpu_write_enable = 1'b0;
  logic        cpu_read_enable = 1'b0;
  logic [31:0] cpu_read_data;
  logic        cpu_ready;
  logic [31:0] disp_addr;
  logic [31:0] disp_write_data;
  logic [3:0]  disp_byte_enable;
  logic        disp_write_enable;
  logic        disp_read_enable;
  logic [31:0] disp_read_data = JUNK;
  logic        disp_ready = 1'b0;
  logic [15:0] stall_count;

  display_write_buffer #(
    .DEPTH        (DEPTH),
    .DISPLAY_BASE (BASE)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .cpu_addr          (cpu_addr),
    .cpu_write_data    (cpu_write_data),
    .cpu_byte_enable   (cpu_byte_enable),
    .cpu_write_enable  (cpu_write_enable),
    .cpu_read_enable   (cpu_read_enable),
    .cpu_read_data     (cpu_read_data),
    .cpu_ready         (cpu_ready),
    .disp_addr         (disp_addr),
    .disp_write_data   (disp_write_data),
    .disp_byte_enable  (disp_byte_enable),
    .disp_write_enable (disp_write_enable),
    .disp_read_enable  (disp_read_enable),
    .disp_read_data    (disp_read_data),
    .disp_ready        (disp_ready),
    .stall_count       (stall_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
  } ent_t;

  ent_t        q[$];
  int          cyc = 0;
  int          acc_cyc = -100;
  int          exp_stall = 0;
  logic [31:0] rd_val = '0;
  logic [31:0] rd_pending = '0;
  logic [31:0] exp_rd = '0;
  logic        inr, st, ld, exp_rdy;
  logic        acc = 1'b0;

  // display-side responder: data valid the cycle after acceptance
  initial begin
    forever begin
      @(negedge clk);
      acc = disp_read_enable && disp_ready;
      @(posedge clk);
      #1;
      disp_read_data = acc ? rd_val : JUNK;
    end
  end

  // model and per-cycle compare
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      q.delete();
      exp_rd    = '0;
      exp_stall = 0;
      acc_cyc   = -100;
      chk("rst_wr_en", disp_write_enable, 0);
      chk("rst_rd_en", disp_read_enable, 0);
      chk("rst_addr", disp_addr, 0);
      chk("rst_wdata", disp_write_data, 0);
      chk("rst_be", disp_byte_enable, 0);
      chk("rst_rdata", cpu_read_data, 0);
      chk("rst_stall", stall_count, 0);
    end else begin
      inr = cpu_addr >= BASE;
      st  = inr && cpu_write_enable;
      ld  = inr && cpu_read_enable && !cpu_write_enable;
      if (cyc == acc_cyc + 2) exp_rd = rd_pending;
      if (st)      exp_rdy = q.size() < DEPTH;
      else if (ld) exp_rdy = (cyc == acc_cyc + 2);
      else         exp_rdy = 1'b1;
      chk("cpu_ready", cpu_ready, exp_rdy);
      chk("cpu_read_data", cpu_read_data, exp_rd);
`ifdef DISPLAY_WB_STATS_EN
      chk("stall_count", stall_count, exp_stall);
`else
      chk("stall_count", stall_count, 0);
`endif
      if (q.size() > 0) begin
        chk("wr_en", disp_write_enable, 1);
        chk("rd_en_order", disp_read_enable, 0);
        chk("head_addr", disp_addr, q[0].a);
        chk("head_data", disp_write_data, q[0].d);
        chk("head_be", disp_byte_enable, q[0].b);
      end else begin
        chk("wr_en_empty", disp_write_enable, 0);
        chk("idle_addr", disp_addr,
            disp_read_enable ? cpu_addr : 32'h0);
        chk("idle_wdata", disp_write_data, 0);
        chk("idle_be", disp_byte_enable, 0);
        if (disp_read_enable) chk("rd_needs_load", ld, 1);
      end
      if ((st || ld) && !exp_rdy && exp_stall < 65535)
        exp_stall++;
      if (disp_read_enable && disp_ready) begin
        acc_cyc    = cyc;
        rd_pending = rd_val;
      end
      if (q.size() > 0 && disp_ready) void'(q.pop_front());
      if (st && exp_rdy)
        q.push_back('{cpu_addr, cpu_write_data, cpu_byte_enable});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [3:0]  be,
                       input logic        we,
                       input logic        re);
    cpu_addr         = a;
    cpu_write_data   = d;
    cpu_byte_enable  = be;
    cpu_write_enable = we;
    cpu_read_enable  = re;
  endtask

  task automatic idle();
    drive(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic do_load(input  logic [31:0] a,
                         output int          lat,
                         output logic [31:0] data,
                         output int          wr_before);
    int  nwr;
    bit  seen;
    nwr       = 0;
    seen      = 0;
    lat       = -1;
    data      = '0;
    wr_before = -1;
    drive(a, 32'h0, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (disp_write_enable && disp_ready) nwr++;
      if (disp_read_enable && !seen) begin
        seen      = 1;
        wr_before = nwr;
      end
      if (cpu_ready) begin
        lat  = i;
        data = cpu_read_data;
        break;
      end
      tick();
    end
    tick();
    idle();
  endtask

  int          lat;
  int          wrb;
  logic [31:0] rdat;
  bit          found;

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", cpu_ready, 1);
    tick();

    // fill the FIFO with the display stalled
    for (int i = 0; i < 8; i++) begin
      drive(BASE + 32'(4 * i), 32'h1000_0000 + 32'(i),
            4'(i + 1), 1'b1, 1'b0);
      @(negedge clk);
      chk("t1_accept", cpu_ready, 1);
      tick();
    end
    drive(BASE + 32'h20, 32'h1000_0008, 4'hF, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_full", cpu_ready, 0);
      tick();
    end
    idle();
    @(negedge clk);
`ifdef DISPLAY_WB_STATS_EN
    chk("t1_stall", stall_count, 3);
`else
    chk("t1_stall", stall_count, 0);
`endif
    tick();

    // drain in order, one per cycle
    disp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t2_wr_en", disp_write_enable, 1);
      chk("t2_addr", disp_addr, BASE + 32'(4 * k));
      chk("t2_data", disp_write_data, 32'h1000_0000 + 32'(k));
      tick();
    end
    @(negedge clk);
    chk("t2_drained", disp_write_enable, 0);
    tick();

    // load after three posted stores
    disp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(BASE + 32'h100 + 32'(4 * i), 32'hA0 + 32'(i),
            4'hF, 1'b1, 1'b0);
      tick();
    end
    rd_val = 32'hCAFE_F00D;
    disp_ready = 1'b1;
    do_load(BASE + 32'h10, lat, rdat, wrb);
    chk("t3_writes_first", 32'(wrb), 3);
    chk("t3_latency", 32'(lat), 6);
    chk("t3_data", rdat, 32'hCAFE_F00D);
    @(negedge clk);
    chk("t3_hold", cpu_read_data, 32'hCAFE_F00D);
    tick();

    // load from an empty FIFO
    rd_val = 32'h1234_5678;
    do_load(BASE + 32'h200, lat, rdat, wrb);
    chk("t4_latency", 32'(lat), 4);
    chk("t4_data", rdat, 32'h1234_5678);
    chk("t4_no_writes", 32'(wrb), 0);

    // out-of-region accesses and dual enables
    disp_ready = 1'b0;
    drive(32'h0000_1000, 32'h1111_1111, 4'hF, 1'b1, 1'b0);
    @(negedge clk);
    chk("t5_oor_ready", cpu_ready, 1);
    tick();
    idle();
    @(negedge clk);
    chk("t5_oor_nopush", disp_write_enable, 0);
    tick();
    drive(32'h0000_2000, 32'h0, 4'h0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t5_oor_ld_ready", cpu_ready, 1);
    chk("t5_oor_ld_nord", disp_read_enable, 0);
    tick();
    drive(BASE + 32'h40, 32'hA5A5_A5A5, 4'h3, 1'b1, 1'b1);
    @(negedge clk);
    chk("t5_dual_ready", cpu_ready, 1);
    tick();
    idle();
    @(negedge clk);
    chk("t5_dual_push", disp_write_enable, 1);
    chk("t5_dual_data", disp_write_data, 32'hA5A5_A5A5);
    chk("t5_dual_be", disp_byte_enable, 4'h3);
    chk("t5_dual_nord", disp_read_enable, 0);
    tick();
    disp_ready = 1'b1;
    repeat (2) tick();

    // full FIFO with a same-cycle pop: no bypass
    disp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(BASE + 32'h400 + 32'(4 * i), 32'hB0 + 32'(i),
            4'hC, 1'b1, 1'b0);
      tick();
    end
    drive(BASE + 32'h420, 32'hB8, 4'hC, 1'b1, 1'b0);
    disp_ready = 1'b1;
    @(negedge clk);
    chk("t7_no_bypass", cpu_ready, 0);
    tick();
    @(negedge clk);
    chk("t7_after_pop", cpu_ready, 1);
    tick();
    idle();
    repeat (12) tick();

    // reset while the read is in flight
    disp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(BASE + 32'h300 + 32'(4 * i), 32'hC0 + 32'(i),
            4'hF, 1'b1, 1'b0);
      tick();
    end
    rd_val = 32'h7777_8888;
    disp_ready = 1'b1;
    drive(BASE + 32'h20, 32'h0, 4'h0, 1'b0, 1'b1);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (disp_read_enable) begin
        found = 1;
        tick();
        break;
      end
      tick();
    end
    chk("t6_rd_issue", 32'(found), 1);
    reset = 1'b1;
    idle();
    @(negedge clk);
    chk("t6_wr_en", disp_write_enable, 0);
    chk("t6_rd_en", disp_read_enable, 0);
    chk("t6_addr", disp_addr, 0);
    chk("t6_rdata", cpu_read_data, 0);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t6_no_capture", cpu_read_data, 0);
      chk("t6_fifo_empty", disp_write_enable, 0);
      chk("t6_ready", cpu_ready, 1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
